// File: rtl/cpu_port_bridge.sv
// cpu_port_bridge: host-side companion to an 8-bit CPU inPort/outPort pair.
// Inbound FIFO carries host bytes to the CPU inPort. Outbound FIFO captures
// CPU OUT writes for the host. Sticky error flags record lost or invalid transfers.
module cpu_port_bridge #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         hostInData,
  input  logic                     hostInValid,
  output logic                     hostInReady,
  output logic [WIDTH-1:0]         cpuInData,
  output logic                     cpuInAvail,
  input  logic                     cpuInPop,
  input  logic [WIDTH-1:0]         cpuOutData,
  input  logic                     cpuOutStrobe,
  output logic [WIDTH-1:0]         hostOutData,
  output logic                     hostOutValid,
  input  logic                     hostOutReady,
  output logic [$clog2(DEPTH):0]   inCount,
  output logic [$clog2(DEPTH):0]   outCount,
  output logic [2:0]               errFlags,
  input  logic                     clearFlags
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};

  // Inbound FIFO state
  logic [WIDTH-1:0] in_mem_q [DEPTH];
  logic [AW-1:0]    in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic [CW-1:0]    in_cnt_q, in_cnt_d;
  logic             in_rdy_q, in_rdy_d;
  logic             in_push_s, in_pop_s, in_udf_s, in_perr_s;

  // Outbound FIFO state
  logic [WIDTH-1:0] out_mem_q [DEPTH];
  logic [AW-1:0]    out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [CW-1:0]    out_cnt_q, out_cnt_d;
  logic             out_push_s, out_pop_s, out_ovf_s;

  logic [2:0]       err_q, err_d;

  // Inbound next-state: ready is registered so no input reaches it combinationally
  always_comb begin
    in_push_s = hostInValid & in_rdy_q;
    in_perr_s = hostInValid & ~in_rdy_q;
    in_pop_s  = cpuInPop & (in_cnt_q != ZERO_CNT);
    in_udf_s  = cpuInPop & (in_cnt_q == ZERO_CNT);
    in_wr_d   = in_wr_q;
    in_rd_d   = in_rd_q;
    in_cnt_d  = in_cnt_q;
    if (in_push_s) begin
      in_wr_d = in_wr_q + AW'(1);
    end else begin
      in_wr_d = in_wr_q;
    end
    if (in_pop_s) begin
      in_rd_d = in_rd_q + AW'(1);
    end else begin
      in_rd_d = in_rd_q;
    end
    case ({in_push_s, in_pop_s})
      2'b10:   in_cnt_d = in_cnt_q + CW'(1);
      2'b01:   in_cnt_d = in_cnt_q - CW'(1);
      default: in_cnt_d = in_cnt_q;
    endcase
    in_rdy_d = (in_cnt_d != FULL_CNT);
  end

  // Outbound next-state: a strobe into a full queue survives only if the host frees a slot
  always_comb begin
    out_pop_s  = hostOutReady & (out_cnt_q != ZERO_CNT);
    out_push_s = cpuOutStrobe & ((out_cnt_q != FULL_CNT) | out_pop_s);
    out_ovf_s  = cpuOutStrobe & ~out_push_s;
    out_wr_d   = out_wr_q;
    out_rd_d   = out_rd_q;
    out_cnt_d  = out_cnt_q;
    if (out_push_s) begin
      out_wr_d = out_wr_q + AW'(1);
    end else begin
      out_wr_d = out_wr_q;
    end
    if (out_pop_s) begin
      out_rd_d = out_rd_q + AW'(1);
    end else begin
      out_rd_d = out_rd_q;
    end
    case ({out_push_s, out_pop_s})
      2'b10:   out_cnt_d = out_cnt_q + CW'(1);
      2'b01:   out_cnt_d = out_cnt_q - CW'(1);
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  // Sticky flags: a set event outranks a simultaneous clear
  always_comb begin
    err_d = 3'b000;
    if (clearFlags) begin
      err_d = {in_perr_s, out_ovf_s, in_udf_s};
    end else begin
      err_d = err_q | {in_perr_s, out_ovf_s, in_udf_s};
    end
  end

  // Control registers: pointers, counts, ready and flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_wr_q   <= {AW{1'b0}};
      in_rd_q   <= {AW{1'b0}};
      in_cnt_q  <= ZERO_CNT;
      in_rdy_q  <= 1'b0;
      out_wr_q  <= {AW{1'b0}};
      out_rd_q  <= {AW{1'b0}};
      out_cnt_q <= ZERO_CNT;
      err_q     <= 3'b000;
    end else begin
      in_wr_q   <= in_wr_d;
      in_rd_q   <= in_rd_d;
      in_cnt_q  <= in_cnt_d;
      in_rdy_q  <= in_rdy_d;
      out_wr_q  <= out_wr_d;
      out_rd_q  <= out_rd_d;
      out_cnt_q <= out_cnt_d;
      err_q     <= err_d;
    end
  end

  // Storage arrays: contents are meaningless until written, so no reset
  always_ff @(posedge clock) begin
    if (in_push_s) begin
      in_mem_q[in_wr_q] <= hostInData;
    end
    if (out_push_s) begin
      out_mem_q[out_wr_q] <= cpuOutData;
    end
  end

  assign hostInReady  = in_rdy_q;
  assign cpuInAvail   = (in_cnt_q != ZERO_CNT);
  assign cpuInData    = cpuInAvail ? in_mem_q[in_rd_q] : {WIDTH{1'b0}};
  assign hostOutValid = (out_cnt_q != ZERO_CNT);
  assign hostOutData  = hostOutValid ? out_mem_q[out_rd_q] : {WIDTH{1'b0}};
  assign inCount      = in_cnt_q;
  assign outCount     = out_cnt_q;
  assign errFlags     = err_q;

endmodule

// File: tb/tb_cpu_port_bridge.sv
// Directed bench for cpu_port_bridge (DEPTH=4, WIDTH=8).
module tb_cpu_port_bridge;
  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] hostInData = 8'h00;
  logic       hostInValid = 1'b0;
  logic       hostInReady;
  logic [7:0] cpuInData;
  logic       cpuInAvail;
  logic       cpuInPop = 1'b0;
  logic [7:0] cpuOutData = 8'h00;
  logic       cpuOutStrobe = 1'b0;
  logic [7:0] hostOutData;
  logic       hostOutValid;
  logic       hostOutReady = 1'b0;
  logic [2:0] inCount, outCount;
  logic [2:0] errFlags;
  logic       clearFlags = 1'b0;

  int errors = 0;
  int checks = 0;

  cpu_port_bridge #(.DEPTH(4), .WIDTH(8)) dut (
    .clock(clock), .reset(reset),
    .hostInData(hostInData), .hostInValid(hostInValid), .hostInReady(hostInReady),
    .cpuInData(cpuInData), .cpuInAvail(cpuInAvail), .cpuInPop(cpuInPop),
    .cpuOutData(cpuOutData), .cpuOutStrobe(cpuOutStrobe),
    .hostOutData(hostOutData), .hostOutValid(hostOutValid), .hostOutReady(hostOutReady),
    .inCount(inCount), .outCount(outCount), .errFlags(errFlags), .clearFlags(clearFlags)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_flags;
    clearFlags = 1'b1;
    tick();
    clearFlags = 1'b0;
  endtask

  logic [7:0] in_model[$];
  logic [7:0] out_model[$];
  logic [7:0] exp_b;

  initial begin
    int in_pushed, in_popped, out_str, out_drained, cyc;
    logic do_out_pop;

    // ---------------- reset ----------------
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("rst_ready", 32'(hostInReady), 32'h0);
    chk("rst_cpuInData", 32'(cpuInData), 32'h0);
    chk("rst_cpuInAvail", 32'(cpuInAvail), 32'h0);
    chk("rst_hostOutValid", 32'(hostOutValid), 32'h0);
    chk("rst_hostOutData", 32'(hostOutData), 32'h0);
    chk("rst_counts", 32'({inCount, outCount}), 32'h0);
    chk("rst_err", 32'(errFlags), 32'h0);
    tick();
    tick();
    chk("rst_ready_held", 32'(hostInReady), 32'h0);
    reset = 1'b1;
    #1;
    chk("rel_ready_before_edge", 32'(hostInReady), 32'h0);
    tick();
    chk("rel_ready_after_edge", 32'(hostInReady), 32'h1);

    // ---------------- inbound fill and drain ----------------
    for (int i = 0; i < 4; i++) begin
      hostInData  = 8'(8'h11 * (i + 1));
      hostInValid = 1'b1;
      tick();
    end
    hostInValid = 1'b0;
    chk("in_full_count", 32'(inCount), 32'h4);
    chk("in_full_ready", 32'(hostInReady), 32'h0);
    chk("in_full_head", 32'(cpuInData), 32'h11);
    chk("in_full_avail", 32'(cpuInAvail), 32'h1);
    for (int i = 0; i < 4; i++) begin
      chk("in_pop_data", 32'(cpuInData), 32'(8'(8'h11 * (i + 1))));
      cpuInPop = 1'b1;
      tick();
    end
    cpuInPop = 1'b0;
    chk("in_drained_count", 32'(inCount), 32'h0);
    chk("in_drained_data", 32'(cpuInData), 32'h0);
    chk("in_drained_err", 32'(errFlags), 32'h0);

    // ---------------- underflow and flag clearing ----------------
    cpuInPop = 1'b1;
    tick();
    cpuInPop = 1'b0;
    chk("udf_err", 32'(errFlags), 32'h1);
    chk("udf_counts", 32'({inCount, outCount}), 32'h0);
    clear_flags();
    chk("udf_cleared", 32'(errFlags), 32'h0);
    clearFlags = 1'b1;
    cpuInPop   = 1'b1;
    tick();
    clearFlags = 1'b0;
    cpuInPop   = 1'b0;
    chk("udf_set_wins_clear", 32'(errFlags), 32'h1);
    clear_flags();

    // ---------------- inbound full: push attempt plus pop ----------------
    for (int i = 0; i < 4; i++) begin
      hostInData  = 8'(8'h11 * (i + 1));
      hostInValid = 1'b1;
      tick();
    end
    hostInData = 8'h99;
    cpuInPop   = 1'b1;
    tick();
    hostInValid = 1'b0;
    cpuInPop    = 1'b0;
    chk("fullpop_count", 32'(inCount), 32'h3);
    chk("fullpop_err", 32'(errFlags), 32'h4);
    chk("fullpop_ready", 32'(hostInReady), 32'h1);
    for (int i = 1; i < 4; i++) begin
      chk("fullpop_data", 32'(cpuInData), 32'(8'(8'h11 * (i + 1))));
      cpuInPop = 1'b1;
      tick();
    end
    cpuInPop = 1'b0;
    chk("fullpop_empty", 32'(inCount), 32'h0);
    clear_flags();

    // ---------------- empty: simultaneous push and pop ----------------
    hostInData  = 8'h77;
    hostInValid = 1'b1;
    cpuInPop    = 1'b1;
    tick();
    hostInValid = 1'b0;
    cpuInPop    = 1'b0;
    chk("emptypp_err", 32'(errFlags), 32'h1);
    chk("emptypp_count", 32'(inCount), 32'h1);
    chk("emptypp_data", 32'(cpuInData), 32'h77);
    cpuInPop = 1'b1;
    tick();
    cpuInPop = 1'b0;
    clear_flags();
    chk("emptypp_done", 32'({inCount, errFlags}), 32'h0);

    // ---------------- outbound overflow ----------------
    hostOutReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cpuOutData   = 8'(8'hA0 + i);
      cpuOutStrobe = 1'b1;
      tick();
      if (i == 0) chk("out_latency", 32'(hostOutData), 32'hA0);
    end
    cpuOutStrobe = 1'b0;
    chk("ovf_count", 32'(outCount), 32'h4);
    chk("ovf_err", 32'(errFlags), 32'h2);
    chk("ovf_valid", 32'(hostOutValid), 32'h1);
    hostOutReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain", 32'(hostOutData), 32'(8'(8'hA0 + i)));
      tick();
    end
    hostOutReady = 1'b0;
    chk("ovf_drained_count", 32'(outCount), 32'h0);
    chk("ovf_drained_valid", 32'(hostOutValid), 32'h0);
    chk("ovf_drained_data", 32'(hostOutData), 32'h0);
    clear_flags();

    // ---------------- outbound full: strobe with host pop ----------------
    for (int i = 0; i < 4; i++) begin
      cpuOutData   = 8'(8'hB0 + i);
      cpuOutStrobe = 1'b1;
      tick();
    end
    cpuOutData   = 8'h55;
    hostOutReady = 1'b1;
    chk("fullstr_head", 32'(hostOutData), 32'hB0);
    tick();
    cpuOutStrobe = 1'b0;
    hostOutReady = 1'b0;
    chk("fullstr_count", 32'(outCount), 32'h4);
    chk("fullstr_err", 32'(errFlags), 32'h0);
    hostOutReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_b = (i == 3) ? 8'h55 : 8'(8'hB1 + i);
      chk("fullstr_drain", 32'(hostOutData), 32'(exp_b));
      tick();
    end
    hostOutReady = 1'b0;
    chk("fullstr_empty", 32'(outCount), 32'h0);

    // ---------------- wrap-around with random stalls ----------------
    in_pushed = 0; in_popped = 0; out_str = 0; out_drained = 0; cyc = 0;
    while ((in_popped < 10 || out_drained < 10) && cyc < 600) begin
      hostInData   = 8'(8'h30 + in_pushed);
      hostInValid  = (in_pushed < 10) && (in_model.size() < 4) && ($urandom_range(0, 1) == 1);
      cpuInPop     = (in_model.size() > 0) && ($urandom_range(0, 1) == 1);
      cpuOutData   = 8'(8'h60 + out_str);
      cpuOutStrobe = (out_str < 10) && (out_model.size() < 4) && ($urandom_range(0, 1) == 1);
      hostOutReady = ($urandom_range(0, 1) == 1);
      do_out_pop   = hostOutReady && (out_model.size() > 0);
      if (cpuInPop) chk("wrap_in_data", 32'(cpuInData), 32'(in_model[0]));
      if (do_out_pop) chk("wrap_out_data", 32'(hostOutData), 32'(out_model[0]));
      tick();
      if (cpuInPop) begin
        void'(in_model.pop_front());
        in_popped++;
      end
      if (hostInValid) begin
        in_model.push_back(hostInData);
        in_pushed++;
      end
      if (do_out_pop) begin
        void'(out_model.pop_front());
        out_drained++;
      end
      if (cpuOutStrobe) begin
        out_model.push_back(cpuOutData);
        out_str++;
      end
      cyc++;
    end
    hostInValid = 1'b0; cpuInPop = 1'b0; cpuOutStrobe = 1'b0; hostOutReady = 1'b0;
    chk("wrap_completed", 32'((in_popped == 10) && (out_drained == 10)), 32'h1);
    chk("wrap_err", 32'(errFlags), 32'h0);
    chk("wrap_counts", 32'({inCount, outCount}), 32'h0);

    // ---------------- reset mid-stream ----------------
    for (int i = 0; i < 3; i++) begin
      hostInData   = 8'(8'hD0 + i);
      hostInValid  = 1'b1;
      cpuOutData   = 8'(8'hE0 + i);
      cpuOutStrobe = 1'b1;
      tick();
    end
    hostInValid = 1'b0; cpuOutStrobe = 1'b0;
    chk("mid_counts", 32'({inCount, outCount}), 32'h1B);
    reset = 1'b0;
    #1;
    chk("mid_rst_cpuInData", 32'(cpuInData), 32'h0);
    chk("mid_rst_avail", 32'({cpuInAvail, hostOutValid, hostInReady}), 32'h0);
    chk("mid_rst_hostOutData", 32'(hostOutData), 32'h0);
    chk("mid_rst_counts", 32'({inCount, outCount}), 32'h0);
    tick();
    reset = 1'b1;
    #1;
    chk("mid_rel_ready_low", 32'(hostInReady), 32'h0);
    tick();
    chk("mid_rel_ready_high", 32'(hostInReady), 32'h1);
    chk("mid_rel_empty", 32'({cpuInAvail, hostOutValid, inCount, outCount}), 32'h0);
    hostInData  = 8'hC1;
    hostInValid = 1'b1;
    cpuOutData   = 8'hC2;
    cpuOutStrobe = 1'b1;
    tick();
    hostInValid = 1'b0; cpuOutStrobe = 1'b0;
    chk("mid_fresh_in", 32'(cpuInData), 32'hC1);
    chk("mid_fresh_out", 32'(hostOutData), 32'hC2);
    chk("mid_fresh_counts", 32'({inCount, outCount}), 32'h9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
